// File: rtl/seq_detect_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_ctrl_if
//  Purpose  : Control, configuration and status bundle for seq_detect_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_detect_ctrl_if #(
    parameter int PAT_W = 7,
    parameter int CNT_W = 8
);
    logic             x;
    logic             start;
    logic             stop;
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [CNT_W-1:0] cfg_limit;
    logic             z;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output x, start, stop, cfg_we, cfg_pattern, cfg_limit,
        input  z, busy, done, match_cnt
    );

    modport slave (
        input  x, start, stop, cfg_we, cfg_pattern, cfg_limit,
        output z, busy, done, match_cnt
    );
endinterface
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_ctrl
//  Purpose  : Armable overlapping serial pattern detector with match limit.
//  Revision : 1.0  initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter int PAT_W = 7,
    parameter int CNT_W = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    seq_detect_ctrl_if.slave   sd
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int              c_FILL_W  = $clog2(PAT_W + 1);
    localparam logic [PAT_W-1:0] c_PAT_RST = (PAT_W == 7) ? PAT_W'(7'b1111001)
                                                          : {PAT_W{1'b1}};
    localparam logic [c_FILL_W-1:0] c_FILL_MAX  = c_FILL_W'(PAT_W);
    localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = {CNT_W{1'b1}};

    state_t              r_state, w_state;
    logic [PAT_W-1:0]    r_pat,   w_pat;
    logic [CNT_W-1:0]    r_lim,   w_lim;
    logic [PAT_W-1:0]    r_hist,  w_hist;
    logic [c_FILL_W-1:0] r_fill,  w_fill;
    logic [CNT_W-1:0]    r_cnt,   w_cnt;
    logic                r_z,     w_z;

    logic [PAT_W-1:0]    w_window;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_match;

    // Window includes the bit being sampled now, so z rises one cycle after it.
    assign w_window  = {r_hist[PAT_W-2:0], sd.x};
    assign w_match   = (r_fill >= c_FILL_LAST) && (w_window == r_pat);
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pat   <= c_PAT_RST;
            r_lim   <= '0;
            r_hist  <= '0;
            r_fill  <= '0;
            r_cnt   <= '0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pat   <= w_pat;
            r_lim   <= w_lim;
            r_hist  <= w_hist;
            r_fill  <= w_fill;
            r_cnt   <= w_cnt;
            r_z     <= w_z;
        end
    end

    always_comb begin
        w_state = r_state;
        w_pat   = r_pat;
        w_lim   = r_lim;
        w_hist  = r_hist;
        w_fill  = r_fill;
        w_cnt   = r_cnt;
        w_z     = 1'b0;

        case (r_state)
            ST_ARMED: begin
                if (sd.stop) begin
                    w_state = ST_IDLE;
                end else begin
                    w_hist = w_window;
                    w_fill = (r_fill == c_FILL_MAX) ? r_fill : r_fill + c_FILL_W'(1);
                    if (w_match) begin
                        w_z   = 1'b1;
                        w_cnt = w_cnt_inc;
                        if ((r_lim != '0) && (w_cnt_inc == r_lim)) begin
                            w_state = ST_DONE;
                        end
                    end
                end
            end
            default: begin
                // IDLE and DONE behave alike: accept config, arm on start unless stopped.
                if (sd.cfg_we) begin
                    w_pat = sd.cfg_pattern;
                    w_lim = sd.cfg_limit;
                end
                if (sd.start && !sd.stop) begin
                    w_state = ST_ARMED;
                    w_hist  = '0;
                    w_fill  = '0;
                    w_cnt   = '0;
                end
            end
        endcase
    end

    assign sd.z         = r_z;
    assign sd.busy      = (r_state == ST_ARMED);
    assign sd.done      = (r_state == ST_DONE);
    assign sd.match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter PAT_W, default 7: pattern length in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8: width of the match counter and the match limit.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 x  input  1: serial data bit, sampled at each rising edge while state is ARMED.
REQ-006 start  input  1: single-cycle pulse that arms detection.
REQ-007 stop  input  1: single-cycle pulse that aborts detection.
REQ-008 cfg_we  input  1: configuration write strobe.
REQ-009 cfg_pattern  input  PAT_W: target pattern; the MSB is the oldest bit.
REQ-010 cfg_limit  input  CNT_W: number of matches before DONE; 0 means unlimited.
REQ-011 z  output  1: registered Moore match flag.
REQ-012 busy  output  1: high while the state is ARMED.
REQ-013 done  output  1: high while the state is DONE.
REQ-014 match_cnt  output  CNT_W: number of matches since the last arm.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ARMED and DONE.
REQ-016 The block SHALL hold a pattern register (pat_r), a limit register (lim_r), a PAT_W-bit history shift register (hist) and a fill counter.
REQ-017 A cfg_we sampled in IDLE or DONE SHALL load pat_r and lim_r at that edge; a cfg_we sampled in ARMED SHALL be ignored.
REQ-018 A start sampled in IDLE or DONE SHALL, at that edge, move the state to ARMED and clear hist, fill, match_cnt and z.
REQ-019 A start sampled in ARMED SHALL be ignored.
REQ-020 A stop sampled in ARMED SHALL, at that edge, move the state to IDLE, clear z and hold match_cnt.
REQ-021 stop SHALL take precedence over start when both are sampled at the same edge.
REQ-022 stop sampled in IDLE or DONE SHALL have no effect.
REQ-023 If cfg_we and start are sampled at the same edge in IDLE or DONE, the new configuration SHALL load and the detector SHALL arm using it.
REQ-024 In ARMED, each edge SHALL shift x into hist (hist <= {hist[PAT_W-2:0], x}) and increment fill, saturating at PAT_W.
REQ-025 A match SHALL be detected at an edge in ARMED when fill >= PAT_W-1 and {hist[PAT_W-2:0], x} == pat_r.
REQ-026 On a match edge, z SHALL be 1 for the following cycle; on any other edge, z SHALL be 0.
REQ-027 Latency: z SHALL go high exactly 1 cycle after the edge that samples the final pattern bit.
REQ-028 Detection SHALL be overlapping: a match SHALL NOT clear hist or fill.
REQ-029 On each match edge, match_cnt SHALL increment by 1, saturating at 2^CNT_W-1 with no wrap-around.
REQ-030 If lim_r != 0 and the incremented match_cnt equals lim_r, the state SHALL move to DONE at that same edge.
REQ-031 In the case of REQ-030, z SHALL still be 1 for that one cycle.
REQ-032 In DONE, x SHALL be ignored, z SHALL be 0, and match_cnt SHALL hold until the next start.
REQ-033 busy and done SHALL be decoded directly from the state register and SHALL never be high together.

Reset
REQ-034 When rst is high at an edge, the block SHALL set state=IDLE, pat_r=PAT_W'b1111001 (for PAT_W=7; otherwise all ones), lim_r=0, hist=0, fill=0.
REQ-035 Reset SHALL drive z=0, busy=0, done=0 and match_cnt=0.
REQ-036 Reset asserted mid-ARMED SHALL abort detection with no further z pulse.
REQ-037 rst SHALL take precedence over start, stop and cfg_we.

Verification
REQ-038 Reset, start, then x=1,1,1,1,0,0,1 -> z=1 for exactly 1 cycle after the 7th bit, match_cnt=1, busy=1.
REQ-039 cfg_pattern=1111111 with lim=0, start, then nine consecutive 1s -> z high 3 consecutive cycles, match_cnt=3.
REQ-040 lim=2 with the default pattern, stream 1111001111001 -> after the 2nd match done=1, busy=0; further matching bits leave match_cnt=2.
REQ-041 Start, feed 1111, stop, then feed 001 -> z stays 0, state=IDLE, match_cnt=0.
REQ-042 While ARMED, cfg_we with pattern 0000000 -> ignored; stream 1111001 still produces z=1.
REQ-043 start and stop pulsed at the same edge in IDLE -> state stays IDLE, busy=0.
